// File: rtl/colour_arbiter.sv
// colour_arbiter: round-robin arbiter sharing one colour-to-rgb converter between two requesters
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_req_a/b            : request lines; i_colour_a/b 3-bit colour codes
//   o_ack_a/b            : one-cycle completion pulses
//   o_rgb_out            : rgb of the most recent completed transaction
//   o_busy               : high while a transaction is in flight
//   o_conv_enable/colour : drive the shared converter; i_conv_rgb is its result
module colour_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_a,
  input  logic        i_req_b,
  input  logic [2:0]  i_colour_a,
  input  logic [2:0]  i_colour_b,
  input  logic [23:0] i_conv_rgb,
  output logic        o_ack_a,
  output logic        o_ack_b,
  output logic [23:0] o_rgb_out,
  output logic        o_busy,
  output logic        o_conv_enable,
  output logic [2:0]  o_conv_colour
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t      r_state;
  logic        r_grant_b;
  logic        r_last_b;
  logic [2:0]  r_cnt;
  logic [23:0] r_rgb;
  logic        r_ack_a;
  logic        r_ack_b;
  logic        r_conv_en;
  logic [2:0]  r_conv_colour;
  logic        w_pick_b;
  // B wins when alone, or when both request and A was granted last
  assign w_pick_b      = i_req_b && (!i_req_a || !r_last_b);
  assign o_ack_a       = r_ack_a;
  assign o_ack_b       = r_ack_b;
  assign o_rgb_out     = r_rgb;
  assign o_busy        = r_state != IDLE;
  assign o_conv_enable = r_conv_en;
  assign o_conv_colour = r_conv_colour;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant_b     <= 1'b0;
      r_last_b      <= 1'b1;
      r_cnt         <= 3'd0;
      r_rgb         <= 24'h000000;
      r_ack_a       <= 1'b0;
      r_ack_b       <= 1'b0;
      r_conv_en     <= 1'b0;
      r_conv_colour <= 3'b000;
    end else begin
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_conv_en <= 1'b0;
      case (r_state)
        IDLE: if (i_req_a || i_req_b) begin
          // the converter colour register doubles as the latched request colour
          r_grant_b     <= w_pick_b;
          r_last_b      <= w_pick_b;
          r_conv_colour <= w_pick_b ? i_colour_b : i_colour_a;
          r_conv_en     <= 1'b1;
          r_state       <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= 3'(LATENCY);
          r_state <= WAIT;
        end
        WAIT: if (r_cnt == 3'd1) begin
          r_rgb   <= i_conv_rgb;
          r_ack_a <= !r_grant_b;
          r_ack_b <= r_grant_b;
          r_state <= DONE;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_colour_arbiter.sv
// tb_colour_arbiter: checks colour_arbiter at LATENCY 1 and 3 against a transaction-level model
module tb_colour_arbiter;
  localparam int LAT [2] = '{1, 3};
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [2:0]  col_a = 3'b000, col_b = 3'b000;
  logic        ack_a [2], ack_b [2], busy [2], cen [2];
  logic [2:0]  ccol [2];
  logic [23:0] rgb [2], conv_rgb [2];
  logic [23:0] p0 [4], p1 [4];
  int          checks = 0, errors = 0, cyc = 0;
  int          st [2], fr [2];
  bit          gw [2], last_b [2];
  logic [2:0]  gc [2], ecc [2];
  logic [23:0] ergb [2];

  always #5 clk = ~clk;

  colour_arbiter #(.LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_req_a(req_a), .i_req_b(req_b),
    .i_colour_a(col_a), .i_colour_b(col_b), .i_conv_rgb(conv_rgb[0]),
    .o_ack_a(ack_a[0]), .o_ack_b(ack_b[0]), .o_rgb_out(rgb[0]), .o_busy(busy[0]),
    .o_conv_enable(cen[0]), .o_conv_colour(ccol[0]));
  colour_arbiter #(.LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .i_req_a(req_a), .i_req_b(req_b),
    .i_colour_a(col_a), .i_colour_b(col_b), .i_conv_rgb(conv_rgb[1]),
    .o_ack_a(ack_a[1]), .o_ack_b(ack_b[1]), .o_rgb_out(rgb[1]), .o_busy(busy[1]),
    .o_conv_enable(cen[1]), .o_conv_colour(ccol[1]));

  function automatic logic [23:0] rgb_of(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // converter models: result valid exactly LATENCY cycles after the enable, junk otherwise
  always @(posedge clk) begin
    p0[0] <= cen[0] ? rgb_of(ccol[0]) : 24'hA5A5A5;
    p1[0] <= cen[1] ? rgb_of(ccol[1]) : 24'hA5A5A5;
    for (int s = 1; s < 4; s++) begin
      p0[s] <= p0[s-1];
      p1[s] <= p1[s-1];
    end
  end
  assign conv_rgb[0] = p0[0];
  assign conv_rgb[1] = p1[2];

  task automatic chk(input string tag, input int d, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s lat%0d cyc %0d got %h exp %h", tag, LAT[d], cyc, got, exp);
    end
  endtask

  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      st[d] = -100; fr[d] = 0; last_b[d] = 1'b1; gw[d] = 1'b0;
      gc[d] = 3'b000; ecc[d] = 3'b000; ergb[d] = 24'h0;
    end
  endtask

  task automatic step(input bit ra, input logic [2:0] ca, input bit rb, input logic [2:0] cb);
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (cyc == st[d] + 1) ecc[d] = gc[d];
      if (cyc == st[d] + LAT[d] + 2) ergb[d] = rgb_of(gc[d]);
      chk("busy", d, 24'(busy[d]), 24'(cyc > st[d] && cyc <= st[d] + LAT[d] + 2));
      chk("conv_en", d, 24'(cen[d]), 24'(cyc == st[d] + 1));
      chk("conv_col", d, 24'(ccol[d]), 24'(ecc[d]));
      chk("ack_a", d, 24'(ack_a[d]), 24'(cyc == st[d] + LAT[d] + 2 && !gw[d]));
      chk("ack_b", d, 24'(ack_b[d]), 24'(cyc == st[d] + LAT[d] + 2 && gw[d]));
      chk("rgb", d, rgb[d], ergb[d]);
    end
    req_a = ra; col_a = ca; req_b = rb; col_b = cb;
    for (int d = 0; d < 2; d++)
      if (cyc >= fr[d] && (ra || rb)) begin
        gw[d] = rb && (!ra || !last_b[d]);
        last_b[d] = gw[d];
        gc[d] = gw[d] ? cb : ca;
        st[d] = cyc;
        fr[d] = cyc + LAT[d] + 3;
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'b000, 0, 3'b000);
  endtask

  task automatic do_reset;
    @(negedge clk);
    cyc++;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, 24'(busy[d]), 24'h0);
      chk("rst_ack_a", d, 24'(ack_a[d]), 24'h0);
      chk("rst_ack_b", d, 24'(ack_b[d]), 24'h0);
      chk("rst_conv_en", d, 24'(cen[d]), 24'h0);
      chk("rst_conv_col", d, 24'(ccol[d]), 24'h0);
      chk("rst_rgb", d, rgb[d], 24'h0);
    end
    model_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    // single request from A
    step(1, 3'b001, 0, 3'b000);
    idle(6);
    chk("single_rgb", 0, rgb[0], 24'h0000FF);
    // sustained contention: A and B alternate
    for (int i = 0; i < 16; i++) step(1, 3'b100, 1, 3'b010);
    idle(6);
    // B's colour changes after grant
    step(0, 3'b000, 1, 3'b110);
    step(0, 3'b000, 1, 3'b110);
    step(0, 3'b000, 0, 3'b000);
    idle(6);
    chk("colour_hold", 0, rgb[0], 24'hFFFF00);
    // reset in WAIT aborts the transaction
    step(1, 3'b010, 0, 3'b000);
    step(0, 3'b000, 0, 3'b000);
    do_reset();
    step(1, 3'b111, 0, 3'b000);
    idle(6);
    chk("post_reset", 0, rgb[0], 24'hFFFFFF);
    // completed transaction then a long idle
    step(1, 3'b011, 0, 3'b000);
    idle(25);
    chk("idle_rgb", 0, rgb[0], 24'h00FFFF);
    chk("idle_busy", 0, 24'(busy[0]), 24'h0);
    // B alone through the 3-cycle converter
    step(0, 3'b000, 1, 3'b101);
    idle(6);
    chk("lat3_rgb", 1, rgb[1], 24'hFF00FF);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
      if (i == 200) do_reset();
    end
    idle(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/colour_arbiter.md
COLOUR_ARBITER -- requirements
Module: colour_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, SHALL set the converter clock cycles from an enabled sample to valid rgb; legal range 1..4.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req_a, req_b  input  1 each  SHALL be request lines, requester A and B.
REQ-005 colour_a, colour_b  input  3 each  SHALL be the requested colour codes; held stable while the matching req is high.
REQ-006 ack_a, ack_b  output  1 each  SHALL be one-cycle completion pulses.
REQ-007 rgb_out  output  24  SHALL be the converted result of the most recent completed transaction.
REQ-008 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-009 conv_enable  output  1  SHALL drive the shared converter's enable.
REQ-010 conv_colour  output  3  SHALL drive the shared converter's colour input.
REQ-011 conv_rgb  input  24  SHALL be the shared converter's rgb output.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, DONE, one transaction at a time.
REQ-013 IDLE: no req high -> stay; any req high -> grant one requester, latch its colour, go ISSUE next cycle.
REQ-014 Arbitration SHALL be round-robin: single requester wins; both high -> the requester not granted last wins.
REQ-015 ISSUE: conv_enable=1 and conv_colour=latched colour for exactly one cycle, wait counter loaded with LATENCY, go WAIT.
REQ-016 WAIT: counter decrements each cycle; on the cycle it reaches 1 SHALL capture conv_rgb into rgb_out and go DONE.
REQ-017 DONE: ack of the granted requester SHALL be 1 for exactly this cycle; other ack 0; next state IDLE.
REQ-018 Latency SHALL be fixed: req sampled in IDLE at cycle t -> ack at cycle t+LATENCY+2 (t+3 for LATENCY=1).
REQ-019 conv_enable SHALL be 0 in every state except ISSUE; conv_colour SHALL hold its last value outside ISSUE.
REQ-020 Requests SHALL be sampled only in IDLE; a req still high in the cycle after its ack SHALL be treated as a new request.
REQ-021 Colour changes on a requester after grant SHALL NOT affect the in-flight transaction.
REQ-022 rgb_out SHALL hold between captures; it SHALL change only at the WAIT->DONE transition.
REQ-023 Last-grant pointer SHALL update only at grant in IDLE.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, ack_a=ack_b=0, busy=0, conv_enable=0, conv_colour=3'b000, rgb_out=24'h000000, counter=0.
REQ-025 Last-grant pointer SHALL reset to B, so A wins the first contested grant.
REQ-026 Reset asserted mid-transaction SHALL abort it with no ack; after release the arbiter SHALL re-sample requests from IDLE.

Verification
REQ-027 Single request, LATENCY=1: req_a=1, colour_a=3'b001 sampled at t -> conv_enable=1 at t+1 with conv_colour=3'b001, ack_a=1 and rgb_out=24'h0000FF at t+3, ack_b never high.
REQ-028 Contention: req_a=req_b=1 held, colour_a=3'b100, colour_b=3'b010 from reset -> acks alternate A,B,A,B with rgb_out 24'hFF0000, 24'h00FF00 alternating, a new grant every 4 cycles.
REQ-029 Colour stability: grant B with colour_b=3'b110, change colour_b to 3'b000 during WAIT -> rgb_out=24'hFFFF00 at ack_b.
REQ-030 Mid-operation reset: pull rst_n low during WAIT -> same instant busy=0, rgb_out=24'h000000, no ack; after release req_a with 3'b111 -> ack_a, rgb_out=24'hFFFFFF.
REQ-031 Idle hold: no requests for 20 cycles after a completed 3'b011 transaction -> conv_enable=0 throughout, rgb_out stays 24'h00FFFF, busy=0.
REQ-032 LATENCY=3: req_b=1, colour_b=3'b101 sampled at t -> ack_b and rgb_out=24'hFF00FF at t+5.
